// File: rtl/frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frame_sequencer_pkg
// Shared APU frame-sequencer definitions: clock/frame-rate constants, the
// per-step tick masks and a helper that decodes a step into its tick set.
// -----------------------------------------------------------------------------
package frame_sequencer_pkg;

   localparam int unsigned SYS_CLK_HZ      = 32'd4194304;
   localparam int unsigned FRAME_RATE_HZ   = 32'd512;
   localparam int unsigned DEFAULT_DIVIDER = SYS_CLK_HZ / FRAME_RATE_HZ;

   // Bit n of each mask says whether entering step n fires that tick.
   localparam logic [7:0] LEN_MASK   = 8'b0101_0101;
   localparam logic [7:0] SWEEP_MASK = 8'b0100_0100;
   localparam logic [7:0] ENV_MASK   = 8'b1000_0000;

   typedef struct packed {
      logic env;
      logic sweep;
      logic len;
   } tick_t;

   // Tick set fired when the sequencer enters step s.
   function automatic tick_t tick_decode(input logic [2:0] s);
      tick_t t;
      t.len   = LEN_MASK[s];
      t.sweep = SWEEP_MASK[s];
      t.env   = ENV_MASK[s];
      return t;
   endfunction

endpackage

// File: rtl/frame_sequencer_prescaler.sv
// -----------------------------------------------------------------------------
// frame_sequencer_prescaler
// Modulo-DIVIDER counter with synchronous clear and count enable.
//   clk        : system clock
//   rstN       : asynchronous active-low reset
//   clear_i    : synchronous clear to 0 (wins over counting)
//   enable_i   : count enable
//   terminal_o : high during the last count of a period while enabled
// -----------------------------------------------------------------------------
module frame_sequencer_prescaler #(
   parameter int unsigned DIVIDER = 32'd8192,
   parameter int unsigned WIDTH   = 32'd13
) (
   input  logic clk,
   input  logic rstN,
   input  logic clear_i,
   input  logic enable_i,
   output logic terminal_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Terminal is decoded independently of clear so a clear on the last count
   // still lets the caller advance.
   assign terminal_o = enable_i && (count_q == WIDTH'(DIVIDER - 32'd1));

   // Next count: clear, wrap on terminal, increment when enabled, else hold.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (terminal_o) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// APU frame sequencer: divides the system clock to the 512 Hz frame rate and
// steps an 8-step sequence, emitting one-cycle length/sweep/envelope pulses.
//   clk               : system clock (4194304 Hz nominal)
//   rstN              : asynchronous active-low reset
//   powerOn           : master APU enable; low holds everything cleared
//   resync            : restart the current step period (step unchanged)
//   lenTick           : 256 Hz length-counter pulse
//   sweepTick         : 128 Hz sweep pulse
//   envTick           : 64 Hz envelope pulse
//   step              : current sequencer step 0..7
//   nextStepClocksLen : high when the next step to fire clocks length
// -----------------------------------------------------------------------------
module frame_sequencer
   import frame_sequencer_pkg::*;
#(
   parameter int unsigned DIVIDER    = DEFAULT_DIVIDER,
   parameter int unsigned PRESCALE_W = 32'd13
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       powerOn,
   input  logic       resync,
   output logic       lenTick,
   output logic       sweepTick,
   output logic       envTick,
   output logic [2:0] step,
   output logic       nextStepClocksLen
);

   logic       terminal_s;
   logic       clear_s;
   logic [2:0] step_q;
   logic [2:0] step_d;
   tick_t      tick_q;
   tick_t      tick_d;

   // Power-off and resync both restart the period; only power-off resets step.
   assign clear_s = ~powerOn | resync;

   frame_sequencer_prescaler #(
      .DIVIDER (DIVIDER),
      .WIDTH   (PRESCALE_W)
   ) u_prescaler (
      .clk        (clk),
      .rstN       (rstN),
      .clear_i    (clear_s),
      .enable_i   (powerOn),
      .terminal_o (terminal_s)
   );

   // Step advance and tick decode for the step being entered.
   always_comb begin
      step_d = step_q;
      tick_d = '0;
      if (!powerOn) begin
         step_d = 3'd0;
      end else if (terminal_s) begin
         step_d = step_q + 3'd1;
         tick_d = tick_decode(step_d);
      end else begin
         step_d = step_q;
      end
   end

   // Step and tick registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         step_q <= 3'd0;
         tick_q <= '0;
      end else begin
         step_q <= step_d;
         tick_q <= tick_d;
      end
   end

   assign lenTick   = tick_q.len;
   assign sweepTick = tick_q.sweep;
   assign envTick   = tick_q.env;
   assign step      = step_q;
   // Next step (step+1) is even exactly when the current step is odd.
   assign nextStepClocksLen = step_q[0];

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       rstN, powerOn, resync;
   logic       lenTick, sweepTick, envTick, nscl;
   logic [2:0] step;

   logic       b_rstN, b_powerOn, b_resync;
   logic       b_len, b_sweep, b_env, b_nscl;
   logic [2:0] b_step;

   int n_checks = 0;
   int n_fail   = 0;
   bit big_done = 1'b0;

   always #5 clk = ~clk;

   frame_sequencer #(.DIVIDER(8), .PRESCALE_W(3)) dut (
      .clk(clk), .rstN(rstN), .powerOn(powerOn), .resync(resync),
      .lenTick(lenTick), .sweepTick(sweepTick), .envTick(envTick),
      .step(step), .nextStepClocksLen(nscl)
   );

   frame_sequencer dut_big (
      .clk(clk), .rstN(b_rstN), .powerOn(b_powerOn), .resync(b_resync),
      .lenTick(b_len), .sweepTick(b_sweep), .envTick(b_env),
      .step(b_step), .nextStepClocksLen(b_nscl)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ticks();
      return {29'd0, envTick, sweepTick, lenTick};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int wait_cyc;
      int exp_step;
      int exp_ticks;   // {env,sweep,len}
      int exp_nscl;
   } vec_t;

   vec_t tbl[8];

   // reference model state for the random phase
   int m_pre, m_step, m_ticks;

   task automatic model_edge(input bit pw, input bit rs);
      bit term;
      if (!pw) begin
         m_pre = 0; m_step = 0; m_ticks = 0;
      end else begin
         term = (m_pre == DIV - 1);
         m_ticks = 0;
         if (term) begin
            m_step  = (m_step + 1) % 8;
            m_ticks = ((m_step == 7) ? 4 : 0) + ((m_step % 4 == 2) ? 2 : 0)
                    + ((m_step % 2 == 0) ? 1 : 0);
         end
         m_pre = (term || rs) ? 0 : m_pre + 1;
      end
   endtask

   // Default-divider run: count ticks over the first 8 full frame steps.
   initial begin
      int nlen, nsweep, nenv, last_len, first_len, spacing_bad;
      nlen = 0; nsweep = 0; nenv = 0; last_len = -1; first_len = -1; spacing_bad = 0;
      b_rstN = 1'b0; b_powerOn = 1'b0; b_resync = 1'b0;
      @(posedge clk); #1;
      b_rstN = 1'b1; b_powerOn = 1'b1;
      for (int c = 1; c <= 65536; c++) begin
         @(posedge clk); #1;
         if (b_len) begin
            nlen++;
            if (last_len < 0) first_len = c;
            else if (c - last_len != 16384) spacing_bad++;
            last_len = c;
         end
         if (b_sweep) nsweep++;
         if (b_env) nenv++;
      end
      check("big_len_count", nlen, 4);
      check("big_sweep_count", nsweep, 2);
      check("big_env_count", nenv, 1);
      check("big_first_len_cycle", first_len, 16384);
      check("big_len_spacing_errors", spacing_bad, 0);
      big_done = 1'b1;
   end

   initial begin
      int bad, guard;
      bit pw, rs;

      tbl[0] = '{8, 1, 3'b000, 1};
      tbl[1] = '{8, 2, 3'b011, 0};
      tbl[2] = '{8, 3, 3'b000, 1};
      tbl[3] = '{8, 4, 3'b001, 0};
      tbl[4] = '{8, 5, 3'b000, 1};
      tbl[5] = '{8, 6, 3'b011, 0};
      tbl[6] = '{8, 7, 3'b100, 1};
      tbl[7] = '{8, 0, 3'b001, 0};

      rstN = 1'b0; powerOn = 1'b0; resync = 1'b0;
      #12;
      check("reset_step", int'(step), 0);
      check("reset_ticks", ticks(), 0);
      rstN = 1'b1;
      cycles(2);
      check("off_step", int'(step), 0);
      check("off_ticks", ticks(), 0);

      // power on, walk one full sequence
      powerOn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycles(1);
         check("pulse_width_ticks", ticks(), 0);
         cycles(tbl[i].wait_cyc - 1);
         check("tbl_step", int'(step), tbl[i].exp_step);
         check("tbl_ticks", ticks(), tbl[i].exp_ticks);
         check("tbl_nscl", int'(nscl), tbl[i].exp_nscl);
      end

      // power dropped mid-period at step 5
      cycles(40);
      cycles(3);
      check("pre_drop_step", int'(step), 5);
      powerOn = 1'b0;
      cycles(1);
      check("drop_step", int'(step), 0);
      check("drop_ticks", ticks(), 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cycles(1);
         if (step != 3'd0 || ticks() != 0) bad++;
      end
      check("off_hold_errors", bad, 0);
      powerOn = 1'b1;
      cycles(7);
      check("repower_early_step", int'(step), 0);
      check("repower_early_ticks", ticks(), 0);
      cycles(1);
      check("repower_first_step", int'(step), 1);
      check("repower_first_ticks", ticks(), 0);

      // resync at prescaler 5
      cycles(5);
      resync = 1'b1;
      cycles(1);
      resync = 1'b0;
      check("resync_step_hold", int'(step), 1);
      cycles(7);
      check("resync_no_early_adv", int'(step), 1);
      cycles(1);
      check("resync_adv_step", int'(step), 2);
      check("resync_adv_ticks", ticks(), 3'b011);

      // resync on the terminal cycle
      cycles(7);
      resync = 1'b1;
      cycles(1);
      resync = 1'b0;
      check("resync_term_step", int'(step), 3);
      cycles(7);
      check("resync_term_hold", int'(step), 3);
      cycles(1);
      check("resync_term_next", int'(step), 4);
      check("resync_term_ticks", ticks(), 3'b001);

      // asynchronous reset at step 6, between clock edges
      cycles(16);
      check("pre_rst_step", int'(step), 6);
      check("pre_rst_ticks", ticks(), 3'b011);
      #2 rstN = 1'b0;
      #1;
      check("async_rst_step", int'(step), 0);
      check("async_rst_ticks", ticks(), 0);
      check("async_rst_nscl", int'(nscl), 0);
      #3 rstN = 1'b1;
      cycles(7);
      check("post_rst_early_step", int'(step), 0);
      cycles(1);
      check("post_rst_first_step", int'(step), 1);
      check("post_rst_first_ticks", ticks(), 0);

      // randomized run against the reference model
      powerOn = 1'b0;
      cycles(1);
      m_pre = 0; m_step = 0; m_ticks = 0;
      for (int i = 0; i < 800; i++) begin
         pw = ($urandom_range(0, 49) != 0);
         rs = ($urandom_range(0, 15) == 0);
         powerOn = pw;
         resync  = rs;
         @(posedge clk);
         model_edge(pw, rs);
         #1;
         check("rand_step", int'(step), m_step);
         check("rand_ticks", ticks(), m_ticks);
         check("rand_nscl", int'(nscl), m_step % 2);
      end
      powerOn = 1'b0;
      resync  = 1'b0;

      guard = 0;
      while (!big_done && guard < 80000) begin
         @(posedge clk);
         guard++;
      end
      check("big_run_completed", int'(big_done), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
